uart_avm_responder: RTL and testbench
=====================================

UART_AVM_RESPONDER -- requirements
Module: uart_avm_responder

Interface
REQ-001 Parameters SHALL be:
- FIFO_DEPTH, default 8: RX and TX FIFO depth in bytes; power of two, at least 2.
- WAIT_CYCLES, default 1: extra waitrequest-high cycles per transfer, range 0..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- avm_clk  in  1  sole clock.
- avm_rst_n  in  1  asynchronous, active-low reset.
- avm_address  in  5  byte address; RX=0, TX=4, STATUS=8.
- avm_read  in  1  master read request.
- avm_readdata  out  32  read return data.
- avm_write  in  1  master write request.
- avm_writedata  in  32  write data; bits [7:0] used.
- avm_waitrequest  out  1  high = transfer not complete.
- host_rx_data  in  8  byte to present to the master via RX.
- host_rx_valid  in  1  host_rx_data valid.
- host_rx_ready  out  1  RX FIFO accepts a byte.
- host_tx_data  out  8  byte written by the master (TX FIFO head, show-ahead).
- host_tx_valid  out  1  TX FIFO non-empty.
- host_tx_ready  in  1  host consumes host_tx_data.

Function
REQ-003 Transfer FSM states SHALL be IDLE, WAIT, ACK.
REQ-004 avm_waitrequest SHALL be 0 only in ACK and 1 in IDLE and WAIT.
REQ-005 In IDLE with avm_read or avm_write high at edge T, the FSM SHALL latch address and kind, then enter WAIT (or ACK directly if WAIT_CYCLES=0).
REQ-006 ACK SHALL be held during exactly cycle T+1+WAIT_CYCLES, one cycle long, then return to IDLE.
REQ-007 Back-to-back transfers SHALL give one ACK per 2+WAIT_CYCLES cycles while the request stays high.
REQ-008 If read and write are both high, the transfer SHALL be a read and the write is discarded.
REQ-009 Address and data changes after latching SHALL be ignored until the next IDLE.
REQ-010 avm_readdata and all side effects SHALL commit at the edge entering ACK.
- avm_readdata holds its value until the next ACK.
- Write transfers leave avm_readdata unchanged.
REQ-011 A read of RX SHALL return {24'b0, RX head} and pop one entry if RX is non-empty; if empty, it returns 0 with no pop.
REQ-012 A read of STATUS SHALL return:
- bit7 = RX non-empty;
- bit6 = TX not full;
- bit0 = tx_overflow;
- bits[15:8] = RX occupancy;
- all other bits 0.
The same read SHALL clear tx_overflow.
REQ-013 A read of TX or of any other address SHALL return 0 with no side effect.
REQ-014 A write to TX SHALL push writedata[7:0] if TX is not full; if full, the byte is dropped and tx_overflow is set (sticky).
REQ-015 Writes to any other address SHALL be acknowledged and ignored.
REQ-016 host_rx_ready SHALL equal !rx_full, registered state, independent of same-cycle pops; a push occurs when host_rx_valid && host_rx_ready.
REQ-017 host_tx_valid SHALL equal !tx_empty, and a pop occurs when host_tx_valid && host_tx_ready.
REQ-018 Simultaneous push and pop on one FIFO in the same cycle SHALL both occur, leaving occupancy unchanged.
- Pop from empty is impossible by construction.
- Push to full is blocked.
REQ-019 Occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits, and pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-020 While avm_rst_n=0, asynchronously:
- state SHALL be IDLE;
- avm_waitrequest 1;
- avm_readdata 0;
- both FIFOs empty, pointers 0;
- tx_overflow 0;
- host_rx_ready 1;
- host_tx_valid 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no ACK and no side effect.
REQ-022 The first request SHALL be accepted in IDLE on the first edge after deassertion.

Verification
REQ-023 Idle status: reset, WAIT_CYCLES=1, read STATUS -> waitrequest low exactly 2 cycles after request, readdata=0x00000040.
REQ-024 RX path: host pushes 0xA5, 0x3C; read STATUS -> 0x000002C0; read RX twice -> 0xA5 then 0x3C; third RX read -> 0, STATUS -> 0x40.
REQ-025 TX path and overflow: 9 TX writes 0x01..0x09 with host_tx_ready=0, DEPTH=8:
- STATUS -> 0x00000001 (TX full, overflow);
- next STATUS read -> 0x00000000;
- host drains 0x01..0x08 in order.
REQ-026 Concurrency: RX pop via ACK and host RX push in the same cycle with 4 entries -> occupancy stays 4, FIFO order preserved, including across pointer wrap after 20 bytes.
REQ-027 Corner cases:
- read+write both high to TX -> returns 0, TX FIFO unchanged;
- reset pulsed during WAIT -> no ACK, waitrequest 1, FIFOs empty;
- WAIT_CYCLES=0 -> ACK 1 cycle after request.

Source files
------------

// File: rtl/uart_avm_responder_if.sv
// Avalon-MM style bus between a master and the UART responder.
// The master drives requests; the responder returns readdata and waitrequest.
interface uart_avm_responder_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/uart_avm_responder.sv
// Avalon-MM register responder bridging a host byte stream to RX/TX FIFOs.
// Each transfer: IDLE -> WAIT (WAIT_CYCLES) -> one-cycle ACK; side effects commit entering ACK.
module uart_avm_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       avm_clk,
  input  logic                       avm_rst_n,
  uart_avm_responder_if.slave        avm,
  input  logic [7:0]                 host_rx_data,
  input  logic                       host_rx_valid,
  output logic                       host_rx_ready,
  output logic [7:0]                 host_tx_data,
  output logic                       host_tx_valid,
  input  logic                       host_tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  ADDR_RX     = 5'd0;
  localparam logic [4:0]  ADDR_TX     = 5'd4;
  localparam logic [4:0]  ADDR_STATUS = 5'd8;
  localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [AW:0] DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ZERO    = (AW + 1)'(0);
  localparam logic [AW:0] CNT_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      wait_cnt_r;
  logic [4:0]      addr_r;
  logic            is_read_r;
  logic [31:0]     readdata_r;
  logic            waitreq_r;

  logic [7:0]      rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   rx_wptr_r, rx_rptr_r;
  logic [AW:0]     rx_count_r;
  logic            rx_ready_r;
  logic [7:0]      tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   tx_wptr_r, tx_rptr_r;
  logic [AW:0]     tx_count_r;
  logic            tx_valid_r;
  logic            tx_overflow_r;

  logic            req_s;
  logic            commit_s;
  logic [4:0]      c_addr_s;
  logic            c_read_s;
  logic            rx_empty_s, tx_full_s;
  logic            rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic            tx_ovf_set_s, status_rd_s;
  logic [AW:0]     rx_count_next_s, tx_count_next_s;
  logic [31:0]     read_value_s;

  function automatic logic [31:0] status_word(input logic [AW:0] rx_cnt, input logic rx_ne,
                                              input logic tx_nf, input logic ovf);
    logic [7:0] occ;
    occ = 8'(rx_cnt);
    return {16'd0, occ, rx_ne, tx_nf, 5'd0, ovf};
  endfunction

  assign req_s        = avm.avm_read | avm.avm_write;
  assign rx_empty_s   = (rx_count_r == CNT_ZERO);
  assign tx_full_s    = (tx_count_r == DEPTH_C);
  assign rx_push_s    = host_rx_valid & rx_ready_r;
  assign rx_pop_s     = commit_s & c_read_s & (c_addr_s == ADDR_RX) & ~rx_empty_s;
  assign tx_push_s    = commit_s & ~c_read_s & (c_addr_s == ADDR_TX) & ~tx_full_s;
  assign tx_ovf_set_s = commit_s & ~c_read_s & (c_addr_s == ADDR_TX) & tx_full_s;
  assign status_rd_s  = commit_s & c_read_s & (c_addr_s == ADDR_STATUS);
  assign tx_pop_s     = tx_valid_r & host_tx_ready;

  assign avm.avm_readdata    = readdata_r;
  assign avm.avm_waitrequest = waitreq_r;
  assign host_rx_ready       = rx_ready_r;
  assign host_tx_valid       = tx_valid_r;
  assign host_tx_data        = tx_mem_r[tx_rptr_r];

  // Commit strobe for the edge that enters ACK, with the transfer it belongs to.
  always_comb begin
    commit_s = 1'b0;
    c_addr_s = addr_r;
    c_read_s = is_read_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s && (WAIT_CYCLES == 0)) begin
          commit_s = 1'b1;
          c_addr_s = avm.avm_address;
          c_read_s = avm.avm_read;
        end else begin
          commit_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      default: commit_s = 1'b0;
    endcase
  end

  // Read data selected by the committing address, sampled from pre-commit FIFO state.
  always_comb begin
    read_value_s = 32'd0;
    case (c_addr_s)
      ADDR_RX: begin
        if (rx_empty_s) begin
          read_value_s = 32'd0;
        end else begin
          read_value_s = {24'd0, rx_mem_r[rx_rptr_r]};
        end
      end
      ADDR_STATUS: read_value_s = status_word(rx_count_r, ~rx_empty_s, ~tx_full_s, tx_overflow_r);
      default:     read_value_s = 32'd0;
    endcase
  end

  // Next occupancy for both FIFOs; simultaneous push and pop cancel.
  always_comb begin
    rx_count_next_s = rx_count_r;
    tx_count_next_s = tx_count_r;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_next_s = rx_count_r + CNT_ONE;
      2'b01:   rx_count_next_s = rx_count_r - CNT_ONE;
      default: rx_count_next_s = rx_count_r;
    endcase
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_next_s = tx_count_r + CNT_ONE;
      2'b01:   tx_count_next_s = tx_count_r - CNT_ONE;
      default: tx_count_next_s = tx_count_r;
    endcase
  end

  // Transfer FSM with registered waitrequest and readdata.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      addr_r     <= 5'd0;
      is_read_r  <= 1'b0;
      readdata_r <= 32'd0;
      waitreq_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          waitreq_r <= 1'b1;
          if (req_s) begin
            addr_r    <= avm.avm_address;
            is_read_r <= avm.avm_read;
            if (WAIT_CYCLES == 0) begin
              state_r   <= ST_ACK;
              waitreq_r <= 1'b0;
            end else begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r   <= ST_ACK;
            waitreq_r <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
            waitreq_r  <= 1'b1;
          end
        end
        ST_ACK: begin
          state_r   <= ST_IDLE;
          waitreq_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          waitreq_r <= 1'b1;
        end
      endcase
      if (commit_s && c_read_s) begin
        readdata_r <= read_value_s;
      end
    end
  end

  // FIFO pointers, occupancy, host handshake flags and sticky overflow.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_wptr_r     <= PTR_ZERO;
      rx_rptr_r     <= PTR_ZERO;
      rx_count_r    <= CNT_ZERO;
      rx_ready_r    <= 1'b1;
      tx_wptr_r     <= PTR_ZERO;
      tx_rptr_r     <= PTR_ZERO;
      tx_count_r    <= CNT_ZERO;
      tx_valid_r    <= 1'b0;
      tx_overflow_r <= 1'b0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
      rx_count_r <= rx_count_next_s;
      tx_count_r <= tx_count_next_s;
      rx_ready_r <= (rx_count_next_s != DEPTH_C);
      tx_valid_r <= (tx_count_next_s != CNT_ZERO);
      if (tx_ovf_set_s) begin
        tx_overflow_r <= 1'b1;
      end else if (status_rd_s) begin
        tx_overflow_r <= 1'b0;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge avm_clk) begin
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= host_rx_data;
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= avm.avm_writedata[7:0];
  end

endmodule

// File: tb/tb_uart_avm_responder.sv
// Scoreboard bench for uart_avm_responder: transfers queue their expected
// readdata, and a negedge monitor compares whenever waitrequest drops.
module tb_uart_avm_responder;

  localparam int W = 1;
  localparam logic [4:0] A_RX = 5'd0, A_TX = 5'd4, A_ST = 5'd8;

  logic avm_clk = 1'b0;
  logic avm_rst_n;
  always #5 avm_clk = ~avm_clk;

  uart_avm_responder_if bus ();
  uart_avm_responder_if bus0 ();

  logic [7:0] host_rx_data, h0_rx_data;
  logic       host_rx_valid, h0_rx_valid;
  logic       host_rx_ready, h0_rx_ready;
  logic [7:0] host_tx_data, h0_tx_data;
  logic       host_tx_valid, h0_tx_valid;
  logic       host_tx_ready, h0_tx_ready;

  uart_avm_responder #(.FIFO_DEPTH(8), .WAIT_CYCLES(W)) dut (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .avm(bus.slave),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready)
  );

  uart_avm_responder #(.FIFO_DEPTH(8), .WAIT_CYCLES(0)) dut0 (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .avm(bus0.slave),
    .host_rx_data(h0_rx_data), .host_rx_valid(h0_rx_valid), .host_rx_ready(h0_rx_ready),
    .host_tx_data(h0_tx_data), .host_tx_valid(h0_tx_valid), .host_tx_ready(h0_tx_ready)
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
    string       name;
  } sb_t;

  sb_t exp_q[$];
  sb_t mon_e;
  logic [7:0] rx_model[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per ACK cycle.
  always @(negedge avm_clk) begin
    if (avm_rst_n === 1'b1 && bus.avm_waitrequest === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ACK expected none");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd) check(mon_e.name, bus.avm_readdata, mon_e.data);
      end
    end
  end

  task automatic xfer(input string name, input logic rd, input logic wr, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp,
                      input logic push_rx, input logic [7:0] push_byte);
    sb_t e;
    int  cycles;
    bit  done;
    e.rd = rd; e.data = exp; e.name = name;
    exp_q.push_back(e);
    @(posedge avm_clk); #1;
    bus.avm_read = rd; bus.avm_write = wr; bus.avm_address = addr; bus.avm_writedata = wdata;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 50) begin
      @(posedge avm_clk); #1;
      cycles++;
      if (push_rx) begin
        host_rx_valid = (cycles == 1);
        host_rx_data  = push_byte;
      end
      if (bus.avm_waitrequest == 1'b0) done = 1'b1;
    end
    bus.avm_read = 1'b0; bus.avm_write = 1'b0; host_rx_valid = 1'b0;
    check({"latency_", name}, 32'(cycles), 32'(1 + W));
  endtask

  task automatic host_push(input logic [7:0] b);
    @(posedge avm_clk); #1;
    host_rx_valid = 1'b1; host_rx_data = b;
    @(posedge avm_clk); #1;
    host_rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    avm_rst_n = 1'b0;
    bus.avm_read = 1'b0; bus.avm_write = 1'b0; bus.avm_address = 5'd0; bus.avm_writedata = 32'd0;
    bus0.avm_read = 1'b0; bus0.avm_write = 1'b0; bus0.avm_address = 5'd0; bus0.avm_writedata = 32'd0;
    host_rx_data = 8'd0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;
    h0_rx_data = 8'd0; h0_rx_valid = 1'b0; h0_tx_ready = 1'b0;

    repeat (3) @(posedge avm_clk);
    #1;
    check("rst_waitreq", 32'(bus.avm_waitrequest), 32'd1);
    check("rst_readdata", bus.avm_readdata, 32'd0);
    check("rst_rx_ready", 32'(host_rx_ready), 32'd1);
    check("rst_tx_valid", 32'(host_tx_valid), 32'd0);

    // WAIT_CYCLES=0 instance: request present at the first edge after release.
    @(negedge avm_clk);
    avm_rst_n = 1'b1;
    bus0.avm_read = 1'b1; bus0.avm_address = A_ST;
    @(posedge avm_clk); #1;
    check("w0_ack", 32'(bus0.avm_waitrequest), 32'd0);
    check("w0_status", bus0.avm_readdata, 32'h0000_0040);
    bus0.avm_read = 1'b0;

    xfer("idle_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0040, 1'b0, 8'd0);

    host_push(8'hA5);
    host_push(8'h3C);
    xfer("rx_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_02C0, 1'b0, 8'd0);
    xfer("rx_read0", 1'b1, 1'b0, A_RX, 32'd0, 32'h0000_00A5, 1'b0, 8'd0);
    xfer("rx_read1", 1'b1, 1'b0, A_RX, 32'd0, 32'h0000_003C, 1'b0, 8'd0);
    xfer("rx_empty_read", 1'b1, 1'b0, A_RX, 32'd0, 32'd0, 1'b0, 8'd0);
    xfer("rx_status_empty", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0040, 1'b0, 8'd0);
    xfer("tx_read", 1'b1, 1'b0, A_TX, 32'd0, 32'd0, 1'b0, 8'd0);

    for (int i = 1; i <= 9; i++)
      xfer("tx_write", 1'b0, 1'b1, A_TX, 32'hFFFF_FF00 | 32'(i), 32'd0, 1'b0, 8'd0);
    xfer("tx_ovf_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0001, 1'b0, 8'd0);
    xfer("tx_ovf_cleared", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0000, 1'b0, 8'd0);
    xfer("unmapped_write", 1'b0, 1'b1, 5'd12, 32'h55, 32'd0, 1'b0, 8'd0);
    check("write_keeps_readdata", bus.avm_readdata, 32'd0);
    host_tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge avm_clk);
      check("tx_drain_valid", 32'(host_tx_valid), 32'd1);
      check("tx_drain_data", 32'(host_tx_data), 32'(i));
    end
    @(negedge avm_clk);
    check("tx_drained", 32'(host_tx_valid), 32'd0);
    host_tx_ready = 1'b0;

    xfer("rd_wr_both", 1'b1, 1'b1, A_TX, 32'h77, 32'd0, 1'b0, 8'd0);
    @(negedge avm_clk);
    check("rd_wr_no_tx_push", 32'(host_tx_valid), 32'd0);
    xfer("rd_wr_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0040, 1'b0, 8'd0);

    // Concurrent ACK pop and host push at occupancy 4, across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      host_push(8'h10 + 8'(i));
      rx_model.push_back(8'h10 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      logic [7:0] nb, hd;
      nb = 8'h14 + 8'(i);
      hd = rx_model.pop_front();
      rx_model.push_back(nb);
      xfer("conc_read", 1'b1, 1'b0, A_RX, 32'd0, {24'd0, hd}, 1'b1, nb);
    end
    xfer("conc_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_04C0, 1'b0, 8'd0);
    while (rx_model.size() > 0) begin
      logic [7:0] hd;
      hd = rx_model.pop_front();
      xfer("conc_drain", 1'b1, 1'b0, A_RX, 32'd0, {24'd0, hd}, 1'b0, 8'd0);
    end

    // Reset in WAIT: no ACK, no pop, everything back to reset values.
    host_push(8'hEE);
    host_push(8'hDD);
    xfer("pre_reset_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_02C0, 1'b0, 8'd0);
    @(posedge avm_clk); #1;
    bus.avm_read = 1'b1; bus.avm_address = A_RX;
    @(posedge avm_clk); #1;
    check("in_wait_waitreq", 32'(bus.avm_waitrequest), 32'd1);
    avm_rst_n = 1'b0;
    bus.avm_read = 1'b0;
    #1;
    check("mid_rst_waitreq", 32'(bus.avm_waitrequest), 32'd1);
    check("mid_rst_readdata", bus.avm_readdata, 32'd0);
    check("mid_rst_rx_ready", 32'(host_rx_ready), 32'd1);
    check("mid_rst_tx_valid", 32'(host_tx_valid), 32'd0);
    repeat (2) @(posedge avm_clk);
    @(negedge avm_clk);
    avm_rst_n = 1'b1;
    xfer("post_rst_status", 1'b1, 1'b0, A_ST, 32'd0, 32'h0000_0040, 1'b0, 8'd0);
    xfer("post_rst_rx", 1'b1, 1'b0, A_RX, 32'd0, 32'd0, 1'b0, 8'd0);

    repeat (4) @(posedge avm_clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
